// File: rtl/cmplx_sq_avs.sv
// cmplx_sq_avs: Avalon-MM responder computing (a + jb)^2 through an IDLE -> MUL -> COMB sequence.
// Define CMPLX_SQ_IRQ_EN to build the avs_irq output and the CTRL.IRQ_EN bit.
module cmplx_sq_avs (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic [2:0]  avs_address,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic        avs_read,
   output logic [31:0] avs_readdata
`ifdef CMPLX_SQ_IRQ_EN
   ,
   output logic        avs_irq
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_COMB = 2'd2
   } state_t;

   state_t             state_reg;
   logic signed [15:0] a_reg, b_reg;
   logic signed [15:0] op_a_reg, op_b_reg;
   logic signed [31:0] aa_reg, bb_reg, ab_reg;
   logic signed [31:0] re_reg, im_reg;
   logic               done_reg, ovf_reg;
   logic [31:0]        readdata_reg;
   logic               irq_en;

   logic               wr_a, wr_b, wr_ctrl, wr_status;
   logic               start_acc, done_clr, comb_last;
   logic               done_next, ovf_next, ovf_calc;
   logic signed [31:0] ext_a, ext_b, re_next, im_next;
   logic [31:0]        rd_mux;
   logic               unused_wdata;

   assign wr_a      = avs_write && (avs_address == 3'd0);
   assign wr_b      = avs_write && (avs_address == 3'd1);
   assign wr_ctrl   = avs_write && (avs_address == 3'd2);
   assign wr_status = avs_write && (avs_address == 3'd3);

   assign start_acc = wr_ctrl && avs_writedata[0] && (state_reg == S_IDLE);
   assign done_clr  = wr_status && avs_writedata[1];
   assign comb_last = (state_reg == S_COMB);

   assign ext_a   = {{16{op_a_reg[15]}}, op_a_reg};
   assign ext_b   = {{16{op_b_reg[15]}}, op_b_reg};
   assign re_next = aa_reg - bb_reg;
   assign im_next = {ab_reg[30:0], 1'b0};
   // Doubling a*b overflows only when a*b = 2^30, i.e. a = b = -32768.
   assign ovf_calc = ab_reg[31] ^ ab_reg[30];

   assign unused_wdata = &{1'b0, avs_writedata[31:16]};

   always_comb begin
      done_next = done_reg;
      ovf_next  = ovf_reg;
      if (comb_last) begin
         done_next = 1'b1;
         ovf_next  = ovf_calc;
      end else if (start_acc) begin
         done_next = 1'b0;
         ovf_next  = 1'b0;
      end else if (done_clr) begin
         done_next = 1'b0;
      end
   end

   // A and B read back sign-extended to 32 bits.
   always_comb begin
      rd_mux = 32'd0;
      case (avs_address)
         3'd0:    rd_mux = {{16{a_reg[15]}}, a_reg};
         3'd1:    rd_mux = {{16{b_reg[15]}}, b_reg};
         3'd2:    rd_mux = {30'd0, irq_en, 1'b0};
         3'd3:    rd_mux = {29'd0, ovf_reg, done_reg, (state_reg != S_IDLE)};
         3'd4:    rd_mux = re_reg;
         3'd5:    rd_mux = im_reg;
         default: rd_mux = 32'd0;
      endcase
   end

`ifdef CMPLX_SQ_IRQ_EN
   logic irq_en_reg, irq_en_next, irq_reg;
   assign irq_en_next = wr_ctrl ? avs_writedata[1] : irq_en_reg;
   assign irq_en      = irq_en_reg;
   assign avs_irq     = irq_reg;

   // irq tracks the post-edge DONE so it rises and falls on the same edge as DONE.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         irq_en_reg <= 1'b0;
         irq_reg    <= 1'b0;
      end else begin
         irq_en_reg <= irq_en_next;
         irq_reg    <= done_next & irq_en_next;
      end
   end
`else
   assign irq_en = 1'b0;
`endif

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_reg    <= S_IDLE;
         a_reg        <= '0;
         b_reg        <= '0;
         op_a_reg     <= '0;
         op_b_reg     <= '0;
         aa_reg       <= '0;
         bb_reg       <= '0;
         ab_reg       <= '0;
         re_reg       <= '0;
         im_reg       <= '0;
         done_reg     <= 1'b0;
         ovf_reg      <= 1'b0;
         readdata_reg <= '0;
      end else begin
         if (wr_a)
            a_reg <= avs_writedata[15:0];
         if (wr_b)
            b_reg <= avs_writedata[15:0];
         if (avs_read)
            readdata_reg <= rd_mux;
         done_reg <= done_next;
         ovf_reg  <= ovf_next;

         case (state_reg)
            S_IDLE: begin
               if (start_acc) begin
                  op_a_reg  <= a_reg;
                  op_b_reg  <= b_reg;
                  state_reg <= S_MUL;
               end
            end
            S_MUL: begin
               aa_reg    <= ext_a * ext_a;
               bb_reg    <= ext_b * ext_b;
               ab_reg    <= ext_a * ext_b;
               state_reg <= S_COMB;
            end
            S_COMB: begin
               re_reg    <= re_next;
               im_reg    <= im_next;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign avs_readdata = readdata_reg;

endmodule

// File: tb/tb_cmplx_sq_avs.sv
// Self-checking bench for cmplx_sq_avs: directed register-map scenarios plus randomized bus traffic
// compared every cycle against an arithmetic reference model. Honors CMPLX_SQ_IRQ_EN.
module tb_cmplx_sq_avs;

   logic        clk_clk       = 1'b0;
   logic        reset_reset_n = 1'b0;
   logic [2:0]  avs_address   = 3'd0;
   logic        avs_write     = 1'b0;
   logic [31:0] avs_writedata = 32'd0;
   logic        avs_read      = 1'b0;
   logic [31:0] avs_readdata;
`ifdef CMPLX_SQ_IRQ_EN
   logic        avs_irq;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   bit checking_on = 1'b0;

   always #5 clk_clk = ~clk_clk;

   cmplx_sq_avs dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .avs_address   (avs_address),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_read      (avs_read),
      .avs_readdata  (avs_readdata)
`ifdef CMPLX_SQ_IRQ_EN
      ,
      .avs_irq       (avs_irq)
`endif
   );

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   logic signed [15:0] m_a, m_b, m_op_a, m_op_b;
   logic [31:0]        m_re, m_im, exp_rd;
   bit                 m_done, m_ovf, m_irq_en;
   int                 calc_left;
   bit                 m_finishing, m_start;
   longint             pa, pb, two_ab;

   function automatic logic [31:0] model_read(input logic [2:0] addr);
      case (addr)
         3'd0:    return 32'(int'(m_a));
         3'd1:    return 32'(int'(m_b));
         3'd2:    return m_irq_en ? 32'd2 : 32'd0;
         3'd3:    return (m_ovf ? 32'd4 : 32'd0) + (m_done ? 32'd2 : 32'd0) + ((calc_left != 0) ? 32'd1 : 32'd0);
         3'd4:    return m_re;
         3'd5:    return m_im;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         m_a = 0; m_b = 0; m_op_a = 0; m_op_b = 0;
         m_re = 0; m_im = 0; exp_rd = 0;
         m_done = 0; m_ovf = 0; m_irq_en = 0;
         calc_left = 0;
      end else begin
         if (avs_read)
            exp_rd = model_read(avs_address);
         m_finishing = (calc_left == 1);
         m_start = avs_write && (avs_address == 3'd2) && avs_writedata[0] && (calc_left == 0);
         if (calc_left > 0)
            calc_left--;
         if (m_finishing) begin
            pa = m_op_a;
            pb = m_op_b;
            two_ab = 2 * pa * pb;
            m_re = 32'(pa * pa - pb * pb);
            m_im = 32'(two_ab);
            m_ovf = (two_ab > 64'sd2147483647);
            m_done = 1;
         end
         if (avs_write) begin
            case (avs_address)
               3'd0: m_a = avs_writedata[15:0];
               3'd1: m_b = avs_writedata[15:0];
`ifdef CMPLX_SQ_IRQ_EN
               3'd2: m_irq_en = avs_writedata[1];
`endif
               3'd3: if (avs_writedata[1] && !m_finishing) m_done = 0;
               default: ;
            endcase
         end
         if (m_start) begin
            m_op_a = m_a;
            m_op_b = m_b;
            calc_left = 2;
            m_done = 0;
            m_ovf = 0;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk_clk) begin
      if (checking_on) begin
         check("readdata_model", avs_readdata, exp_rd);
`ifdef CMPLX_SQ_IRQ_EN
         check("irq_model", {31'd0, avs_irq}, {31'd0, m_done && m_irq_en});
`endif
      end
   end

   // ---------------- bus tasks ----------------
   task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
      avs_address = addr; avs_writedata = data; avs_write = 1'b1;
      @(posedge clk_clk); #1;
      avs_write = 1'b0;
      $display("WR addr=%0d data=0x%08h", addr, data);
   endtask

   task automatic read_check(input logic [2:0] addr, input logic [31:0] exp, input string name);
      avs_address = addr; avs_read = 1'b1;
      @(posedge clk_clk); #1;
      avs_read = 1'b0;
      $display("RD addr=%0d data=0x%08h (%s)", addr, avs_readdata, name);
      check(name, avs_readdata, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_clk); #1;
      end
   endtask

   logic [31:0] rnd_data;
   int          sel;

   initial begin
      repeat (2) @(posedge clk_clk);
      #1;
      checking_on = 1'b1;
      check("reset_readdata", avs_readdata, 32'd0);
      reset_reset_n = 1'b1;
      idle(1);

      // (3 + 4j)^2 = -7 + 24j
      bus_write(3'd0, 32'd3);
      bus_write(3'd1, 32'd4);
      bus_write(3'd2, 32'd1);
      read_check(3'd3, 32'd1, "busy_after_start");
      read_check(3'd3, 32'd1, "busy_comb");
      read_check(3'd3, 32'd2, "done_3_4");
      read_check(3'd4, 32'hFFFF_FFF9, "re_3_4");
      read_check(3'd5, 32'h0000_0018, "im_3_4");

      // a = b = -32768: 2ab wraps
      bus_write(3'd0, 32'h0000_8000);
      bus_write(3'd1, 32'h0000_8000);
      read_check(3'd0, 32'hFFFF_8000, "a_signext");
      bus_write(3'd2, 32'd1);
      idle(2);
      read_check(3'd3, 32'd6, "status_ovf");
      read_check(3'd4, 32'd0, "re_min");
      read_check(3'd5, 32'h8000_0000, "im_min");

      // Back-to-back START: the second is ignored, operands 5,6 give -11 + 60j
      bus_write(3'd0, 32'd5);
      bus_write(3'd1, 32'd6);
      bus_write(3'd2, 32'd1);
      bus_write(3'd2, 32'd1);
      bus_write(3'd0, 32'd1);
      bus_write(3'd1, 32'd1);
      read_check(3'd3, 32'd2, "one_done");
      read_check(3'd4, 32'hFFFF_FFF5, "re_first_ops");
      read_check(3'd5, 32'd60, "im_first_ops");
      read_check(3'd0, 32'd1, "a_updated");
      bus_write(3'd3, 32'd2);
      idle(3);
      read_check(3'd3, 32'd0, "no_second_done");

      // DONE set and clear on the same edge: DONE wins
      bus_write(3'd2, 32'd1);
      idle(1);
      bus_write(3'd3, 32'd2);
      read_check(3'd3, 32'd2, "done_set_wins");
      bus_write(3'd3, 32'd2);
      read_check(3'd3, 32'd0, "done_cleared");

      // Reset in the middle of a calculation
      bus_write(3'd0, 32'd7);
      bus_write(3'd1, 32'd8);
      read_check(3'd0, 32'd7, "a_before_reset");
      bus_write(3'd2, 32'd1);
      reset_reset_n = 1'b0;
      #1;
      check("async_reset_rd", avs_readdata, 32'd0);
      @(posedge clk_clk); #1;
      reset_reset_n = 1'b1;
      read_check(3'd0, 32'd0, "a_reset");
      read_check(3'd1, 32'd0, "b_reset");
      idle(3);
      read_check(3'd3, 32'd0, "no_done_after_reset");
      read_check(3'd4, 32'd0, "re_reset");
      read_check(3'd5, 32'd0, "im_reset");
      bus_write(3'd0, 32'd2);
      bus_write(3'd2, 32'd1);
      idle(2);
      read_check(3'd4, 32'd4, "re_after_reset");
      read_check(3'd5, 32'd0, "im_after_reset");

      // Unused addresses and CTRL readback
      bus_write(3'd6, 32'hDEAD_BEEF);
      read_check(3'd6, 32'd0, "addr6");
      read_check(3'd7, 32'd0, "addr7");
      bus_write(3'd2, 32'd1);
      read_check(3'd2, 32'd0, "ctrl_start_reads0");
      idle(2);
      bus_write(3'd2, 32'd2);
`ifdef CMPLX_SQ_IRQ_EN
      read_check(3'd2, 32'd2, "ctrl_irq_en");
      bus_write(3'd3, 32'd2);
      bus_write(3'd2, 32'd3);
      idle(2);
      check("irq_rises", {31'd0, avs_irq}, 32'd1);
      bus_write(3'd3, 32'd2);
      check("irq_falls", {31'd0, avs_irq}, 32'd0);
      bus_write(3'd2, 32'd0);
`else
      read_check(3'd2, 32'd0, "ctrl_no_irq_en");
`endif

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         sel = $urandom_range(0, 199);
         if (sel < 2) begin
            reset_reset_n = 1'b0;
            @(posedge clk_clk); #1;
            reset_reset_n = 1'b1;
            $display("RST pulse");
         end else begin
            case ($urandom_range(0, 5))
               0: rnd_data = 32'h0000_8000;
               1: rnd_data = 32'h0000_7FFF;
               2: rnd_data = 32'h0000_FFFF;
               default: rnd_data = $urandom;
            endcase
            sel = $urandom_range(0, 9);
            if (sel < 3)
               avs_address = 3'd2;
            else
               avs_address = 3'($urandom_range(0, 7));
            avs_writedata = rnd_data;
            avs_write = ($urandom_range(0, 1) == 1);
            avs_read  = ($urandom_range(0, 9) < 6);
            @(posedge clk_clk); #1;
            $display("RND addr=%0d wr=%0d rd=%0d data=0x%08h readdata=0x%08h",
                     avs_address, avs_write, avs_read, avs_writedata, avs_readdata);
            avs_write = 1'b0;
            avs_read  = 1'b0;
         end
      end

      idle(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
